// File: rtl/acc_sequencer.sv
// rtl/acc_sequencer.sv - walks output pixels, streams PMEM psum reads through the SFU and emits ReLU results
// Optional ACC_SEQ_BASE_ADDR_EN adds a base_addr port sampled on start; otherwise the PMEM base is 0.
module acc_sequencer #(
    parameter int psum_bw  = 16,
    parameter int col      = 8,
    parameter int len_kij  = 9,
    parameter int len_onij = 16,
    parameter int addr_bw  = 11,
    parameter int sfu_lat  = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
`ifdef ACC_SEQ_BASE_ADDR_EN
    input  logic [addr_bw-1:0]                   base_addr,
`endif
    output logic                                 busy,
    output logic                                 done,
    output logic                                 CEN_pmem,
    output logic                                 WEN_pmem,
    output logic [addr_bw-1:0]                   A_pmem,
    output logic                                 acc,
    output logic                                 acc_clr,
    input  logic [psum_bw*col-1:0]               sfp_out,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [psum_bw*col-1:0]               out_data,
    output logic [$clog2(len_onij)-1:0]          out_idx
);

    localparam int JW = (len_kij > 1) ? $clog2(len_kij) : 1;
    localparam int OW = $clog2(len_onij);
    localparam int WW = (sfu_lat > 2) ? $clog2(sfu_lat - 1) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(len_kij - 1);
    localparam logic [OW-1:0] O_LAST = OW'(len_onij - 1);
    localparam logic [WW-1:0] W_LAST = WW'((sfu_lat > 1) ? sfu_lat - 2 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_RD, S_TAIL, S_RELU, S_WAIT, S_CAPT, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [JW-1:0]     j, j_nxt;
    logic [OW-1:0]     o, o_nxt;
    logic [WW-1:0]     w, w_nxt;
    logic [addr_bw-1:0] base_q;

    logic                    busy_d, done_d, cen_d, acc_d, clr_d, valid_d;
    logic [addr_bw-1:0]      addr_d;
    logic [psum_bw*col-1:0]  data_d;
    logic [OW-1:0]           idx_d;

`ifdef ACC_SEQ_BASE_ADDR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            base_q <= '0;
        else if (state == S_IDLE && start)
            base_q <= base_addr;
    end
`else
    assign base_q = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            j     <= '0;
            o     <= '0;
            w     <= '0;
        end else begin
            state <= state_nxt;
            j     <= j_nxt;
            o     <= o_nxt;
            w     <= w_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        j_nxt     = j;
        o_nxt     = o;
        w_nxt     = w;
        case (state)
            S_IDLE: if (start) begin
                state_nxt = S_CLR;
                o_nxt     = '0;
            end
            S_CLR: begin
                state_nxt = S_RD;
                j_nxt     = '0;
            end
            S_RD: begin
                if (j == J_LAST) state_nxt = S_TAIL;
                else             j_nxt     = j + 1'b1;
            end
            S_TAIL: state_nxt = S_RELU;
            S_RELU: begin
                w_nxt     = '0;
                state_nxt = (sfu_lat > 1) ? S_WAIT : S_CAPT;
            end
            S_WAIT: begin
                if (w == W_LAST) state_nxt = S_CAPT;
                else             w_nxt     = w + 1'b1;
            end
            S_CAPT: if (out_ready) begin
                if (o == O_LAST) begin
                    state_nxt = S_DONE;
                end else begin
                    o_nxt     = o + 1'b1;
                    state_nxt = S_CLR;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with the state they describe.
    always_comb begin
        busy_d  = (state_nxt != S_IDLE);
        done_d  = (state_nxt == S_DONE);
        cen_d   = (state_nxt != S_RD);
        acc_d   = (state_nxt == S_RD && j_nxt != '0) || (state_nxt == S_TAIL);
        clr_d   = (state_nxt == S_CLR);
        valid_d = (state_nxt == S_CAPT);
        addr_d  = A_pmem;
        if (state_nxt == S_RD)
            addr_d = base_q + addr_bw'(int'(j_nxt) * len_onij) + addr_bw'(o_nxt);
        data_d  = out_data;
        idx_d   = out_idx;
        if (state_nxt == S_CAPT && state != S_CAPT) begin
            data_d = sfp_out;
            idx_d  = o_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            CEN_pmem  <= 1'b1;
            A_pmem    <= '0;
            acc       <= 1'b0;
            acc_clr   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else begin
            busy      <= busy_d;
            done      <= done_d;
            CEN_pmem  <= cen_d;
            A_pmem    <= addr_d;
            acc       <= acc_d;
            acc_clr   <= clr_d;
            out_valid <= valid_d;
            out_data  <= data_d;
            out_idx   <= idx_d;
        end
    end

    assign WEN_pmem = 1'b1;

endmodule

// File: tb/tb_acc_sequencer.sv
// tb/tb_acc_sequencer.sv - scoreboard bench for acc_sequencer with PMEM and SFU models
module tb_acc_sequencer;

    localparam int W = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          out_ready;
    logic [10:0]   base_v;
    logic          busy, done, CEN_pmem, WEN_pmem, acc, acc_clr, out_valid;
    logic [10:0]   A_pmem;
    logic [W-1:0]  sfp_out, out_data;
    logic [3:0]    out_idx;

    acc_sequencer dut (
        .clk(clk), .reset(rst), .start(start),
`ifdef ACC_SEQ_BASE_ADDR_EN
        .base_addr(base_v),
`endif
        .busy(busy), .done(done), .CEN_pmem(CEN_pmem), .WEN_pmem(WEN_pmem),
        .A_pmem(A_pmem), .acc(acc), .acc_clr(acc_clr), .sfp_out(sfp_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int t0 = 0;
    int acc_cnt = 0, done_cnt = 0, hs_cnt = 0, wen_bad = 0;
    logic [10:0]  reads[$];
    logic [W-1:0] exp_data[$];
    logic [3:0]   exp_idx[$];

    // PMEM word at offset 16*kij+o holds that offset in every column; SFU accumulates and applies ReLU.
    logic [W-1:0]  rdata;
    logic [15:0]   accum[8];
    logic [10:0]   off;
    assign off = A_pmem - base_v;

    always @(posedge clk) cyc++;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
            for (int c = 0; c < 8; c++) accum[c] <= '0;
        end else begin
            if (!CEN_pmem) rdata <= {8{5'b0, off}};
            if (acc_clr)
                for (int c = 0; c < 8; c++) accum[c] <= '0;
            else if (acc)
                for (int c = 0; c < 8; c++) accum[c] <= accum[c] + rdata[c*16 +: 16];
        end
    end

    always_comb begin
        sfp_out = '0;
        for (int c = 0; c < 8; c++)
            sfp_out[c*16 +: 16] = accum[c][15] ? 16'd0 : accum[c];
    end

    task automatic chk(input bit ok, input string name, input logic [W-1:0] got, input logic [W-1:0] expv);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (acc) acc_cnt++;
            if (!CEN_pmem) reads.push_back(A_pmem);
            if (done) done_cnt++;
            if (!WEN_pmem) wen_bad++;
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (exp_data.size() == 0) begin
                    chk(1'b0, "unexpected_output", W'(out_idx), '0);
                end else begin
                    logic [W-1:0] ed;
                    logic [3:0]   ei;
                    ed = exp_data.pop_front();
                    ei = exp_idx.pop_front();
                    chk(out_data == ed, "out_data", out_data, ed);
                    chk(out_idx == ei, "out_idx", W'(out_idx), W'(ei));
                end
            end
        end
    end

    task automatic push_exp();
        for (int o = 0; o < 16; o++) begin
            exp_data.push_back({8{16'(576 + 9 * o)}});
            exp_idx.push_back(4'(o));
        end
    endtask

    task automatic start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(output int lat);
        int k;
        lat = -1;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - t0;
                break;
            end
        end
        if (k == 2000) chk(1'b0, "done_timeout", '0, 1);
    endtask

    task automatic wait_clr(input int n);
        int seen = 0;
        for (int k = 0; k < 2000 && seen < n; k++) begin
            @(negedge clk);
            if (acc_clr) seen++;
        end
        if (seen < n) chk(1'b0, "clr_timeout", W'(seen), W'(n));
    endtask

    initial begin
        int lat, d0, h0;
        logic [W-1:0] hold_d;
        logic [3:0]   hold_i;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; base_v = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(busy == 0 && done == 0, "rst_busy_done", {busy, done}, 0);
        chk(CEN_pmem == 1 && WEN_pmem == 1, "rst_cen_wen", {CEN_pmem, WEN_pmem}, 2'b11);
        chk(A_pmem == 0 && acc == 0 && acc_clr == 0, "rst_addr_acc", {A_pmem, acc, acc_clr}, 0);
        chk(out_valid == 0 && out_data == 0 && out_idx == 0, "rst_out", out_data, 0);
        @(posedge clk); #1 rst = 1'b0;

        // sweep 1: address pattern, acc width, overall latency
        reads.delete(); acc_cnt = 0; push_exp();
        start_pulse();
        for (int k = 0; k < 100 && !out_valid; k++) @(negedge clk);
        chk(out_valid == 1, "first_valid", out_valid, 1);
        chk(acc_cnt == 9, "acc_cycles_o0", W'(acc_cnt), 9);
        for (int j = 0; j < 9; j++)
            chk(reads.size() > j && reads[j] == 11'(16 * j), "addr_o0", (reads.size() > j) ? W'(reads[j]) : '1, W'(16 * j));
        wait_done(lat);
        chk(lat == 224, "done_latency", W'(lat), 224);
        @(negedge clk);
        chk(busy == 0 && done == 0, "post_done_idle", {busy, done}, 0);
        chk(exp_data.size() == 0, "sweep1_drained", W'(exp_data.size()), 0);

        // sweep 2: consumer stalls five cycles on o=3, then a start pulse lands during RD of o=7
        push_exp(); hs_cnt = 0; d0 = done_cnt;
        start_pulse();
        wait_clr(4);
        @(posedge clk); #1 out_ready = 1'b0;
        for (int k = 0; k < 100 && !out_valid; k++) @(negedge clk);
        hold_d = out_data; hold_i = out_idx;
        chk(hold_i == 3, "stall_idx", W'(hold_i), 3);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            chk(out_valid == 1 && out_data == hold_d && out_idx == hold_i, "stall_stable", out_data, hold_d);
            chk(CEN_pmem == 1, "stall_no_read", CEN_pmem, 1);
            if (k == 4) begin
                @(posedge clk); #1 out_ready = 1'b1;
            end
        end
        @(negedge clk);
        chk(out_valid == 0, "valid_drop", out_valid, 0);
        wait_clr(4);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(lat);
        repeat (40) @(negedge clk);
        chk(hs_cnt == 16, "handshakes", W'(hs_cnt), 16);
        chk(done_cnt - d0 == 1, "one_done", W'(done_cnt - d0), 1);
        chk(busy == 0, "no_restart", busy, 0);

        // sweep 3: reset during RD of o=5
        push_exp(); hs_cnt = 0; d0 = done_cnt;
        start_pulse();
        wait_clr(6);
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk(CEN_pmem == 1 && acc == 0, "mid_rst_pmem", {CEN_pmem, acc}, 2'b10);
        chk(busy == 0 && out_valid == 0, "mid_rst_busy", {busy, out_valid}, 0);
        h0 = hs_cnt;
        chk(h0 == 5, "partial_handshakes", W'(h0), 5);
        exp_data.delete(); exp_idx.delete();
        @(posedge clk); #1 rst = 1'b0;
        chk(done_cnt == d0, "no_done_on_rst", W'(done_cnt - d0), 0);

        // sweep 4: restart after reset runs from o=0
        reads.delete(); push_exp();
`ifdef ACC_SEQ_BASE_ADDR_EN
        base_v = 11'd2040;
`endif
        start_pulse();
        wait_done(lat);
        chk(lat == 224, "restart_latency", W'(lat), 224);
        chk(exp_data.size() == 0, "sweep4_drained", W'(exp_data.size()), 0);
`ifdef ACC_SEQ_BASE_ADDR_EN
        chk(reads.size() > 1 && reads[0] == 11'd2040 && reads[1] == 11'd8, "base_wrap", (reads.size() > 1) ? W'(reads[1]) : '1, 8);
`else
        chk(reads.size() > 1 && reads[1] == 11'd16, "restart_addr", (reads.size() > 1) ? W'(reads[1]) : '1, 16);
`endif
        chk(wen_bad == 0, "wen_never_low", W'(wen_bad), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
